// File: rtl/gemac_pkg.sv
// Shared types and constants for the GEMAC f36 transmit path.
// Holds the FSM state enum, frame envelope bytes, CRC constants and f36 field helpers.
package gemac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DROP
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

  localparam int F36_SOF    = 32;
  localparam int F36_EOF    = 33;
  localparam int F36_OCC_LO = 34;
  localparam int F36_OCC_HI = 35;

  // Index (0 = MSB byte) of the last valid byte in a word.
  function automatic logic [1:0] occ_last_idx(input logic eof, input logic [1:0] occ);
    logic [1:0] idx;
    idx = 2'd3;
    if (eof) begin
      case (occ)
        2'b01:   idx = 2'd0;
        2'b10:   idx = 2'd1;
        2'b11:   idx = 2'd2;
        default: idx = 2'd3;
      endcase
    end
    return idx;
  endfunction

  function automatic logic [7:0] f36_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/gemac_crc32_d8.sv
// Byte-wide reflected CRC-32 register; one byte folded in per enabled cycle.
// fcs is the complemented register, ready to transmit low byte first.
module gemac_crc32_d8
  import gemac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] fcs
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc_q ^ {24'h0, din};
      for (int i = 0; i < 8; i++) begin
        crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY_REFL) : (crc_d >> 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign fcs = ~crc_q;

endmodule

// File: rtl/gemac_tx_f36.sv
// GMII transmit engine: f36 words in, preamble/SFD/data/pad/FCS/IFG out, one byte per clk125.
// GMII outputs are registered and reflect the state being entered; the client is stalled outside SFD/word boundaries/DROP.
module gemac_tx_f36
  import gemac_pkg::*;
#(
  parameter int IFG_BYTES    = 12,
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter bit FCS_EN       = 1'b1
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic [35:0] tx_f36_data,
  input  logic        tx_f36_src_rdy,
  output logic        tx_f36_dst_rdy,
  input  logic        pause_hold,
  output logic        GMII_TX_EN,
  output logic        GMII_TX_ER,
  output logic [7:0]  GMII_TXD,
  output logic        tx_done,
  output logic        tx_underrun,
  output logic [15:0] tx_len
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN);
  // The IDLE cycle that launches the next preamble is the final gap cycle.
  localparam logic [7:0] IFG_LOAD = (IFG_BYTES > 1) ? 8'(IFG_BYTES - 2) : 8'd0;

  tx_state_e   state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [1:0]  idx_q, idx_d, last_q, last_d, fcs_idx_q, fcs_idx_d;
  logic        eof_q, eof_d;
  logic [15:0] cnt_q, cnt_d, len_q, len_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic [7:0]  txd_q, txd_d;
  logic        done_q, done_d, und_q, und_d;

  logic        in_sof, in_eof, pad_needed;
  logic        load, underrun, finish, to_ifg;
  logic        crc_init, crc_en;
  logic [31:0] fcs;
  logic [1:0]  idx_nxt, fcs_nxt;

  assign in_sof     = tx_f36_data[F36_SOF];
  assign in_eof     = tx_f36_data[F36_EOF];
  assign pad_needed = int'({16'd0, cnt_q}) < MIN_FRAME;
  assign idx_nxt    = idx_q + 2'd1;
  assign fcs_nxt    = fcs_idx_q + 2'd1;

  always_comb begin
    tx_f36_dst_rdy = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: tx_f36_dst_rdy = tx_f36_src_rdy & ~in_sof;
        ST_SFD:  tx_f36_dst_rdy = 1'b1;
        ST_DATA: tx_f36_dst_rdy = (idx_q == last_q) & ~eof_q;
        ST_DROP: tx_f36_dst_rdy = tx_f36_src_rdy;
        default: tx_f36_dst_rdy = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    last_d    = last_q;
    eof_d     = eof_q;
    fcs_idx_d = fcs_idx_q;
    pre_cnt_d = pre_cnt_q;
    ifg_cnt_d = ifg_cnt_q;
    len_d     = len_q;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    txd_d     = 8'h00;
    done_d    = 1'b0;
    und_d     = 1'b0;
    load      = 1'b0;
    underrun  = 1'b0;
    finish    = 1'b0;
    to_ifg    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_f36_src_rdy && in_sof && !pause_hold) begin
          state_d   = ST_PREAMBLE;
          tx_en_d   = 1'b1;
          txd_d     = PREAMBLE_BYTE;
          pre_cnt_d = 4'd1;
        end
      end
      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          txd_d   = SFD_BYTE;
        end else begin
          pre_cnt_d = pre_cnt_q + 4'd1;
          txd_d     = PREAMBLE_BYTE;
        end
      end
      ST_SFD: begin
        if (tx_f36_src_rdy) load = 1'b1;
        else                underrun = 1'b1;
      end
      ST_DATA: begin
        if (idx_q != last_q) begin
          idx_d   = idx_nxt;
          tx_en_d = 1'b1;
          txd_d   = f36_byte(hold_q, idx_nxt);
        end else if (!eof_q) begin
          if (tx_f36_src_rdy) load = 1'b1;
          else                underrun = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      ST_PAD: finish = 1'b1;
      ST_FCS: begin
        if (fcs_idx_q == 2'd3) begin
          to_ifg = 1'b1;
          done_d = 1'b1;
          len_d  = cnt_q;
        end else begin
          fcs_idx_d = fcs_nxt;
          tx_en_d   = 1'b1;
          txd_d     = fcs[{fcs_nxt, 3'b000} +: 8];
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == 8'd0) state_d = ST_IDLE;
        else                   ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      ST_DROP: begin
        if (tx_f36_src_rdy && in_eof) to_ifg = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      if (pad_needed) begin
        state_d = ST_PAD;
        tx_en_d = 1'b1;
        txd_d   = 8'h00;
      end else if (FCS_EN) begin
        state_d   = ST_FCS;
        fcs_idx_d = 2'd0;
        tx_en_d   = 1'b1;
        txd_d     = fcs[7:0];
      end else begin
        to_ifg = 1'b1;
        done_d = 1'b1;
        len_d  = cnt_q;
      end
    end

    if (load) begin
      state_d = ST_DATA;
      hold_d  = tx_f36_data[31:0];
      eof_d   = in_eof;
      last_d  = occ_last_idx(in_eof, tx_f36_data[F36_OCC_HI:F36_OCC_LO]);
      idx_d   = 2'd0;
      tx_en_d = 1'b1;
      txd_d   = tx_f36_data[31:24];
    end

    // Error byte goes out while DROP starts draining the rest of the frame.
    if (underrun) begin
      state_d = ST_DROP;
      tx_en_d = 1'b1;
      tx_er_d = 1'b1;
      txd_d   = 8'h00;
      und_d   = 1'b1;
    end

    if (to_ifg) begin
      if (IFG_BYTES > 1) begin
        state_d   = ST_IFG;
        ifg_cnt_d = IFG_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  assign crc_init = (state_q == ST_IDLE);
  assign crc_en   = (state_d == ST_DATA) || (state_d == ST_PAD);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE)                cnt_d = 16'd0;
    else if (crc_en && cnt_q != 16'hFFFF)  cnt_d = cnt_q + 16'd1;
  end

  gemac_crc32_d8 u_crc (
    .clk   (clk125),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .din   (txd_d),
    .fcs   (fcs)
  );

  always_ff @(posedge clk125) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= 32'd0;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      eof_q     <= 1'b0;
      fcs_idx_q <= 2'd0;
      pre_cnt_q <= 4'd0;
      ifg_cnt_q <= 8'd0;
      cnt_q     <= 16'd0;
      len_q     <= 16'd0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      txd_q     <= 8'h00;
      done_q    <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      eof_q     <= eof_d;
      fcs_idx_q <= fcs_idx_d;
      pre_cnt_q <= pre_cnt_d;
      ifg_cnt_q <= ifg_cnt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
      und_q     <= und_d;
    end
  end

  assign GMII_TX_EN  = tx_en_q;
  assign GMII_TX_ER  = tx_er_q;
  assign GMII_TXD    = txd_q;
  assign tx_done     = done_q;
  assign tx_underrun = und_q;
  assign tx_len      = len_q;

endmodule

// File: tb/tb_gemac_tx_f36.sv
// Directed bench for gemac_tx_f36: a no-pad instance for the CRC check vector, a default instance for the rest.
module tb_gemac_tx_f36;

  logic        clk125 = 1'b0;
  logic        reset;
  logic [35:0] tx_f36_data;
  logic        tx_f36_src_rdy;
  logic        pause_hold;
  logic        sel0;

  logic        rdy_a, en_a, er_a, dn_a, un_a;
  logic [7:0]  txd_a;
  logic [15:0] len_a;
  logic        rdy_b, en_b, er_b, dn_b, un_b;
  logic [7:0]  txd_b;
  logic [15:0] len_b;

  always #4 clk125 = ~clk125;

  gemac_tx_f36 #(.MIN_FRAME(0)) dut_nopad (
    .clk125(clk125), .reset(reset), .tx_f36_data(tx_f36_data), .tx_f36_src_rdy(tx_f36_src_rdy),
    .tx_f36_dst_rdy(rdy_a), .pause_hold(pause_hold), .GMII_TX_EN(en_a), .GMII_TX_ER(er_a),
    .GMII_TXD(txd_a), .tx_done(dn_a), .tx_underrun(un_a), .tx_len(len_a));

  gemac_tx_f36 dut (
    .clk125(clk125), .reset(reset), .tx_f36_data(tx_f36_data), .tx_f36_src_rdy(tx_f36_src_rdy),
    .tx_f36_dst_rdy(rdy_b), .pause_hold(pause_hold), .GMII_TX_EN(en_b), .GMII_TX_ER(er_b),
    .GMII_TXD(txd_b), .tx_done(dn_b), .tx_underrun(un_b), .tx_len(len_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [35:0] w; int gap; } item_t;
  item_t q[$];
  bit    fire = 1'b0;

  function automatic logic [35:0] mk(input bit sof, input bit eof, input logic [1:0] occ, input logic [31:0] d);
    return {occ, eof, sof, d};
  endfunction

  task automatic push(input logic [35:0] w, input int gap);
    item_t it;
    it.w = w;
    it.gap = gap;
    q.push_back(it);
  endtask

  // Driver: inputs change only at negedge; the handshake is decided from settled values before the posedge.
  initial begin
    tx_f36_src_rdy = 1'b0;
    tx_f36_data = '0;
    forever begin
      @(negedge clk125);
      if (fire && q.size() > 0) void'(q.pop_front());
      fire = 1'b0;
      if (q.size() > 0 && q[0].gap > 0) begin
        q[0].gap = q[0].gap - 1;
        tx_f36_src_rdy = 1'b0;
      end else if (q.size() > 0) begin
        tx_f36_src_rdy = 1'b1;
        tx_f36_data = q[0].w;
      end else begin
        tx_f36_src_rdy = 1'b0;
        tx_f36_data = '0;
      end
      #1;
      fire = tx_f36_src_rdy & (sel0 ? rdy_a : rdy_b);
    end
  end

  bit         en_l[$], er_l[$], dn_l[$], un_l[$];
  logic [7:0] txd_l[$];

  initial forever begin
    @(negedge clk125);
    en_l.push_back(sel0 ? en_a : en_b);
    er_l.push_back(sel0 ? er_a : er_b);
    dn_l.push_back(sel0 ? dn_a : dn_b);
    un_l.push_back(sel0 ? un_a : un_b);
    txd_l.push_back(sel0 ? txd_a : txd_b);
  end

  task automatic clr();
    en_l.delete(); er_l.delete(); dn_l.delete(); un_l.delete(); txd_l.delete();
  endtask

  int         n_en, n_er, n_dn, n_un, er_at, un_at;
  int         rs[$], rl[$];
  logic [7:0] got_b[$], exp_b[$], mb[$];

  task automatic analyse();
    n_en = 0; n_er = 0; n_dn = 0; n_un = 0; er_at = -1; un_at = -1;
    rs.delete(); rl.delete(); got_b.delete();
    for (int i = 0; i < en_l.size(); i++) begin
      if (en_l[i]) begin
        got_b.push_back(txd_l[i]);
        n_en++;
        if (i == 0 || !en_l[i-1]) begin
          rs.push_back(i);
          rl.push_back(1);
        end else begin
          rl[rl.size()-1] = rl[rl.size()-1] + 1;
        end
      end
      if (er_l[i]) begin n_er++; er_at = i; end
      if (dn_l[i]) n_dn++;
      if (un_l[i]) begin n_un++; un_at = i; end
    end
  endtask

  // Bitwise reference CRC-32 over mb[].
  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (mb[i]) begin
      c = c ^ {24'h0, mb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk125);
  endtask

  task automatic pulse_reset();
    @(negedge clk125);
    reset = 1'b1;
    q.delete();
    repeat (3) @(negedge clk125);
    reset = 1'b0;
  endtask

  initial begin
    int bad;
    bit seen;
    logic [31:0] fcs_got;
    reset = 1'b1;
    pause_hold = 1'b0;
    sel0 = 1'b0;
    repeat (3) @(negedge clk125);
    reset = 1'b0;
    @(negedge clk125);
    chk("rst tx_en", en_b, 0);
    chk("rst tx_er", er_b, 0);
    chk("rst txd", txd_b, 0);
    chk("rst tx_len", len_b, 0);
    chk("rst dst_rdy", rdy_b, 0);

    // Test 1: reset while in preamble
    cycles(1);
    push(mk(1, 0, 2'b00, 32'hA0A1A2A3), 0);
    push(mk(0, 1, 2'b00, 32'hA4A5A6A7), 0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk125);
      seen = en_b;
    end
    chk("t1 preamble started", seen, 1);
    repeat (3) @(negedge clk125);
    reset = 1'b1;
    @(negedge clk125);
    chk("t1 tx_en", en_b, 0);
    chk("t1 tx_er", er_b, 0);
    chk("t1 txd", txd_b, 0);
    chk("t1 dst_rdy", rdy_b, 0);
    chk("t1 pulses", {dn_b, un_b}, 0);
    q.delete();
    repeat (3) @(negedge clk125);
    reset = 1'b0;
    cycles(5);

    // Test 2: CRC check vector "123456789" on the no-pad instance
    sel0 = 1'b1;
    cycles(2);
    clr();
    push(mk(1, 0, 2'b00, 32'h31323334), 0);
    push(mk(0, 0, 2'b00, 32'h35363738), 0);
    push(mk(0, 1, 2'b01, 32'h39AABBCC), 0);
    cycles(80);
    analyse();
    exp_b.delete();
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_b.push_back(8'(8'h31 + i));
    exp_b.push_back(8'h26); exp_b.push_back(8'h39); exp_b.push_back(8'hF4); exp_b.push_back(8'hCB);
    chk("t2 first tx_en index", (rs.size() > 0) ? rs[0] : -1, 1);
    chk("t2 byte count", got_b.size(), 21);
    for (int i = 0; i < exp_b.size(); i++)
      chk($sformatf("t2 byte%0d", i), (i < got_b.size()) ? got_b[i] : 8'hEE, exp_b[i]);
    chk("t2 tx_done count", n_dn, 1);
    chk("t2 tx_len", len_a, 9);
    chk("t2 underrun count", n_un, 0);
    chk("t2 queue drained", q.size(), 0);

    pulse_reset();
    sel0 = 1'b0;
    cycles(2);

    // Test 3: 14-byte frame padded to 60
    clr();
    push(mk(1, 0, 2'b00, 32'h01020304), 0);
    push(mk(0, 0, 2'b00, 32'h05060708), 0);
    push(mk(0, 0, 2'b00, 32'h090A0B0C), 0);
    push(mk(0, 1, 2'b10, 32'h0D0E7777), 0);
    cycles(110);
    analyse();
    mb.delete();
    for (int i = 1; i <= 14; i++) mb.push_back(8'(i));
    for (int i = 0; i < 46; i++) mb.push_back(8'h00);
    exp_b.delete();
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    foreach (mb[i]) exp_b.push_back(mb[i]);
    chk("t3 run count", rs.size(), 1);
    chk("t3 tx_en cycles", (rl.size() > 0) ? rl[0] : 0, 72);
    bad = 0;
    for (int i = 0; i < 68; i++)
      if (i >= got_b.size() || got_b[i] !== exp_b[i]) bad++;
    chk("t3 bad header/payload/pad bytes", bad, 0);
    fcs_got = (got_b.size() >= 72) ? {got_b[71], got_b[70], got_b[69], got_b[68]} : 32'hDEAD_BEEF;
    chk("t3 fcs", fcs_got, crc_ref());
    chk("t3 tx_len", len_b, 60);
    chk("t3 tx_done count", n_dn, 1);

    // Test 4: underrun after the second of five words
    cycles(2);
    clr();
    push(mk(1, 0, 2'b00, 32'h11121314), 0);
    push(mk(0, 0, 2'b00, 32'h15161718), 0);
    push(mk(0, 0, 2'b00, 32'h191A1B1C), 10);
    push(mk(0, 0, 2'b00, 32'h1D1E1F20), 0);
    push(mk(0, 1, 2'b00, 32'h21222324), 0);
    cycles(80);
    analyse();
    chk("t4 run count", rs.size(), 1);
    chk("t4 tx_en cycles", (rl.size() > 0) ? rl[0] : 0, 17);
    chk("t4 tx_er count", n_er, 1);
    chk("t4 tx_er position", er_at, (rs.size() > 0) ? rs[0] + 16 : -2);
    chk("t4 tx_er txd", (er_at >= 0) ? txd_l[er_at] : 8'hEE, 8'h00);
    chk("t4 tx_underrun count", n_un, 1);
    chk("t4 tx_underrun position", un_at, er_at);
    chk("t4 tx_done count", n_dn, 0);
    chk("t4 queue drained", q.size(), 0);

    // Test 5: back-to-back frames
    cycles(2);
    clr();
    push(mk(1, 0, 2'b00, 32'h41424344), 0);
    push(mk(0, 1, 2'b00, 32'h45464748), 0);
    push(mk(1, 0, 2'b00, 32'h51525354), 0);
    push(mk(0, 1, 2'b11, 32'h55565700), 0);
    cycles(220);
    analyse();
    chk("t5 run count", rs.size(), 2);
    chk("t5 gap", (rs.size() >= 2) ? rs[1] - (rs[0] + rl[0]) : -1, 12);
    chk("t5 second frame first byte", (rs.size() >= 2) ? txd_l[rs[1]] : 8'hEE, 8'h55);
    chk("t5 second frame length", (rl.size() >= 2) ? rl[1] : 0, 72);
    chk("t5 tx_done count", n_dn, 2);

    // Test 6: stray word, then pause hold-off
    cycles(2);
    clr();
    pause_hold = 1'b1;
    push(mk(0, 0, 2'b00, 32'hDEADBEEF), 0);
    push(mk(1, 0, 2'b00, 32'h61626364), 0);
    push(mk(0, 1, 2'b00, 32'h65666768), 0);
    cycles(20);
    analyse();
    chk("t6 stray discarded", q.size(), 2);
    chk("t6 no tx_en while held", n_en, 0);
    @(negedge clk125);
    pause_hold = 1'b0;
    @(negedge clk125);
    chk("t6 tx_en after release", en_b, 1);
    repeat (12) @(negedge clk125);
    pause_hold = 1'b1;
    cycles(110);
    pause_hold = 1'b0;
    analyse();
    chk("t6 run count", rs.size(), 1);
    chk("t6 tx_en cycles", (rl.size() > 0) ? rl[0] : 0, 72);
    chk("t6 tx_done count", n_dn, 1);
    chk("t6 tx_len", len_b, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
